uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receive half of the SoC UART: 8N1 frames on the `uart_rx` pad in, bytes out to the bus-side UART register block.
- Contains a 2-flop input synchroniser, a bit-timing FSM clocked from the system clock with a programmable divisor, and a small byte FIFO with a valid/ready pop port.
- Sticky framing and overflow flags are exposed for the status register.

Parameters:
- W_DIV, 16: width of baud divisor input.
- FIFO_DEPTH, 8: RX byte FIFO entries; power of 2, at least 2.
- W_LEVEL, 4: width of fill-level output; must hold FIFO_DEPTH, i.e. $clog2(FIFO_DEPTH)+1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: receiver enable.
- div, input, W_DIV: clk cycles per bit; legal 4..2^W_DIV-1.
- rx, input, 1: asynchronous serial line; idle high.
- rdata, output, 8: FIFO head byte.
- rvalid, output, 1: FIFO non-empty.
- rready, input, 1: pop head when rvalid && rready.
- level, output, W_LEVEL: current FIFO occupancy.
- err_frame, output, 1: sticky; stop bit sampled low.
- err_overflow, output, 1: sticky; byte received while FIFO full.
- err_clear, input, 1: clears both sticky flags.

Behaviour:
- Reset values:
  - Synchroniser flops = 1.
  - FSM = IDLE.
  - FIFO empty: rvalid=0, level=0, rdata=0.
  - err_frame=0, err_overflow=0.
  - Bit counter, divisor counter and shift register = 0.
- rx passes through 2 flops (rx_s). All timing below is relative to rx_s; rx_s lags rx by 2 cycles.
- Divisor is latched into div_q on leaving IDLE. Changes to div mid-frame have no effect until the next frame.
- FSM states:
  - IDLE: wait for rx_s==0 with en=1. On detection, load divisor counter with div>>1 (floor) and go to START.
  - START: count down. At 0, sample rx_s.
    - Sample 0: load counter with div_q-1, clear bit count, go to DATA.
    - Sample 1 (false start / glitch): go to IDLE, no flags.
  - DATA: count down. At 0, shift rx_s into bit 7 of the shift register (LSB first) and reload div_q-1. After the 8th sample, go to STOP.
  - STOP: at counter 0, sample rx_s.
    - Sample 1, FIFO not full: push byte; go to IDLE.
    - Sample 1, FIFO full: drop byte, set err_overflow; go to IDLE.
    - Sample 0: drop byte, set err_frame, go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. A held-low line (break) therefore yields exactly one framing error.
- Timing: the start bit is validated at mid-bit, and every data/stop sample is exactly div_q cycles after the previous one.
- Push latency: rvalid/level update in the cycle after the stop-bit sample.
- en=0 in any state: FSM returns to IDLE on the next edge. A partial frame is discarded with no flags. FIFO contents and sticky flags are retained.
- FIFO:
  - Synchronous, first-word fall-through; rdata is valid whenever rvalid=1.
  - Pop and push in the same cycle:
    - FIFO full: both occur, level unchanged, no overflow.
    - FIFO empty: push only (no pop possible).
  - Pointers wrap modulo FIFO_DEPTH. level = occupancy, 0..FIFO_DEPTH.
- Sticky flags: err_clear in the same cycle as a new error event leaves the flag set (set wins).
- rst asserted mid-frame: everything returns to reset values on that edge, FIFO flushed.

Test Plan:
1. div=16; send 0xA5 (8N1) on rx → rvalid=1 with rdata=0xA5 and level=1, 1 cycle after the stop-bit sample (2+8+9×16 cycles after the start edge); flags stay 0.
2. FIFO_DEPTH=8; send 9 bytes 0x00..0x08, rready=0 → level=8, err_overflow=1, rdata=0x00. Pop 8 times → sequence 0x00..0x07, then rvalid=0. err_clear pulse → err_overflow=0.
3. div=16; 4-cycle low glitch on rx → no push, FSM back in IDLE, no flags. Then a valid 0x3C frame → received correctly.
4. Send 0x55 with stop bit forced low, then hold rx low for 40 bit times → single err_frame=1, no push. Release rx, send 0x12 → rdata=0x12.
5. FIFO full and rready=1 in the same cycle as a stop-bit sample → push accepted, level stays 8, err_overflow=0.
6. Assert rst, or drop en, mid-data-bit of a frame:
   - rst: rvalid=0, level=0, flags=0.
   - en: FIFO preserved, partial byte discarded.
   - In both cases, the next full frame 0xC3 is received intact.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, divisor-timed bit FSM, FWFT byte FIFO
// with valid/ready pop port, and sticky framing/overflow status flags.
module uart_rx #(
  parameter int W_DIV      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int W_LEVEL    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [W_DIV-1:0]   div,
  input  logic               rx,
  output logic [7:0]         rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic [W_LEVEL-1:0] level,
  output logic               err_frame,
  output logic               err_overflow,
  input  logic               err_clear
);

  localparam int W_PTR = $clog2(FIFO_DEPTH);
  localparam logic [W_LEVEL-1:0] LEVEL_FULL = W_LEVEL'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rx_meta_q, rx_s_q;
  logic [2:0]       state_q, state_d;
  logic [W_DIV-1:0] cnt_q, cnt_d;
  logic [W_DIV-1:0] div_q, div_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [W_PTR-1:0]   rd_ptr_q, wr_ptr_q;
  logic [W_LEVEL-1:0] level_q, level_d;
  logic               err_frame_q, err_ovf_q;

  logic cnt_zero, push_req, frame_evt;
  logic fifo_empty, fifo_full, push, pop, ovf_evt;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = div >> 1;
          div_d   = div;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          state_d   = S_DATA;
          cnt_d     = div_q - 1'b1;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = div_q - 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          push_req = 1'b1;
          state_d  = S_IDLE;
        end else begin
          frame_evt = 1'b1;
          state_d   = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Disabling abandons any partial frame silently.
    if (!en) begin
      state_d   = S_IDLE;
      push_req  = 1'b0;
      frame_evt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_FULL);
  assign pop        = !fifo_empty && rready;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_evt    = push_req && fifo_full && !pop;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      err_frame_q <= frame_evt | (err_frame_q & ~err_clear);
      err_ovf_q   <= ovf_evt   | (err_ovf_q   & ~err_clear);
    end
  end

  assign rdata        = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rvalid       = !fifo_empty;
  assign level        = level_q;
  assign err_frame    = err_frame_q;
  assign err_overflow = err_ovf_q;

endmodule
